// File: rtl/clint.sv
// Core-local interruptor: msip / mtimecmp / mtime registers behind a
// single-outstanding valid/ready MMIO port, plus software and timer IRQs.
module clint #(
   parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
   parameter int unsigned TICK_DIV  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [63:0] req_addr,
   input  logic        req_we,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_strb,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic        irq_software_o,
   output logic        irq_timer_o,
   output logic [63:0] mtime_o
);

   localparam int unsigned       DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);

   localparam logic [12:0] WORD_MSIP  = 13'h0000;
   localparam logic [12:0] WORD_CMP   = 13'h0800;
   localparam logic [12:0] WORD_MTIME = 13'h17FF;

   typedef enum logic {ST_IDLE, ST_RESP} state_t;

   state_t            state;
   logic              msip;
   logic [63:0]       mtimecmp;
   logic [63:0]       mtime;
   logic [DIV_W-1:0]  div_cnt;

   logic              in_win;
   logic              sel_msip;
   logic              sel_cmp;
   logic              sel_time;
   logic              accept;
   logic              wr;
   logic              tick;
   logic [63:0]       wmask;
   logic [63:0]       rd_val;
   logic              unused_addr_lsb;

   // The word offset alone selects a register; byte lanes come from req_strb.
   assign unused_addr_lsb = ^req_addr[2:0];

   assign in_win   = (req_addr[63:16] == BASE_ADDR[63:16]);
   assign sel_msip = in_win && (req_addr[15:3] == WORD_MSIP);
   assign sel_cmp  = in_win && (req_addr[15:3] == WORD_CMP);
   assign sel_time = in_win && (req_addr[15:3] == WORD_MTIME);

   assign accept = req_valid && req_ready;
   assign wr     = accept && req_we;
   assign tick   = (div_cnt == DIV_LAST);

   always_comb begin
      wmask = '0;
      for (int i = 0; i < 8; i++) begin
         wmask[i*8 +: 8] = {8{req_strb[i]}};
      end
   end

   always_comb begin
      rd_val = '0;
      if (sel_msip)      rd_val = {63'd0, msip};
      else if (sel_cmp)  rd_val = mtimecmp;
      else if (sel_time) rd_val = mtime;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         msip        <= 1'b0;
         mtimecmp    <= '1;
         mtime       <= '0;
         div_cnt     <= '0;
         irq_timer_o <= 1'b0;
      end else begin
         div_cnt     <= tick ? '0 : div_cnt + DIV_W'(1);
         irq_timer_o <= (mtime >= mtimecmp);
         // A software write to mtime swallows a coincident tick entirely.
         if (wr && sel_time) begin
            mtime <= (mtime & ~wmask) | (req_wdata & wmask);
         end else if (tick) begin
            mtime <= mtime + 64'd1;
         end
         if (wr && sel_cmp) begin
            mtimecmp <= (mtimecmp & ~wmask) | (req_wdata & wmask);
         end
         if (wr && sel_msip && req_strb[0]) begin
            msip <= req_wdata[0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state      <= ST_RESP;
                  req_ready  <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_rdata <= req_we ? '0 : rd_val;
                  resp_err   <= !(sel_msip || sel_cmp || sel_time);
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  state      <= ST_IDLE;
                  req_ready  <= 1'b1;
                  resp_valid <= 1'b0;
               end
            end
            default: begin
               state      <= ST_IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign irq_software_o = msip;
   assign mtime_o        = mtime;

endmodule

// File: tb/tb_clint.sv
// Bench for clint: two instances (TICK_DIV 1 and 4) share one request bus and
// are checked every cycle against a register-map model plus literal cases.
module tb_clint;

   localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
   localparam int DIV0 = 1;
   localparam int DIV1 = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic        resp_ready = 1'b0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [7:0]  req_strb = '0;

   logic [1:0]  req_ready, resp_valid, resp_err, irq_sw, irq_t;
   logic [63:0] resp_rdata [2];
   logic [63:0] mtime [2];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   clint #(.BASE_ADDR(BASE), .TICK_DIV(DIV0)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready[0]), .req_addr(req_addr),
      .req_we(req_we), .req_wdata(req_wdata), .req_strb(req_strb),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
      .irq_software_o(irq_sw[0]), .irq_timer_o(irq_t[0]), .mtime_o(mtime[0])
   );

   clint #(.BASE_ADDR(BASE), .TICK_DIV(DIV1)) dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready[1]), .req_addr(req_addr),
      .req_we(req_we), .req_wdata(req_wdata), .req_strb(req_strb),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
      .irq_software_o(irq_sw[1]), .irq_timer_o(irq_t[1]), .mtime_o(mtime[1])
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic        m_idle, m_msip, m_err;
   logic [63:0] m_cmp;
   logic [63:0] m_time [2];
   logic [63:0] m_pre  [2];
   logic [63:0] m_rd   [2];
   logic        m_irq  [2];
   int          m_cyc;
   int          m_reg;

   function automatic int divk(input int k);
      return (k == 0) ? DIV0 : DIV1;
   endfunction

   // 0 = msip, 1 = mtimecmp, 2 = mtime, 3 = unmapped
   function automatic int region(input logic [63:0] a);
      logic [15:0] off;
      if (a[63:16] != BASE[63:16]) return 3;
      off = a[15:0] & 16'hFFF8;
      if (off == 16'h0000) return 0;
      if (off == 16'h4000) return 1;
      if (off == 16'hBFF8) return 2;
      return 3;
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                          input logic [7:0] strb);
      logic [63:0] r;
      r = old_v;
      for (int b = 0; b < 8; b++) begin
         if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
      end
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_idle = 1'b1; m_msip = 1'b0; m_err = 1'b0; m_cmp = '1; m_cyc = 0;
         for (int k = 0; k < 2; k++) begin
            m_time[k] = '0; m_rd[k] = '0; m_irq[k] = 1'b0;
         end
      end else begin
         m_reg = region(req_addr);
         for (int k = 0; k < 2; k++) begin
            m_pre[k]  = m_time[k];
            m_irq[k]  = (m_pre[k] >= m_cmp);
            m_time[k] = m_pre[k] + (((m_cyc % divk(k)) == divk(k) - 1) ? 64'd1 : 64'd0);
         end
         if (m_idle && req_valid) begin
            m_idle = 1'b0;
            m_err  = (m_reg == 3);
            for (int k = 0; k < 2; k++) begin
               m_rd[k] = '0;
               if (!req_we) begin
                  if (m_reg == 0) m_rd[k] = {63'd0, m_msip};
                  if (m_reg == 1) m_rd[k] = m_cmp;
                  if (m_reg == 2) m_rd[k] = m_pre[k];
               end
            end
            if (req_we) begin
               if (m_reg == 0 && req_strb[0]) m_msip = req_wdata[0];
               if (m_reg == 1) m_cmp = merge(m_cmp, req_wdata, req_strb);
               if (m_reg == 2) begin
                  for (int k = 0; k < 2; k++) m_time[k] = merge(m_pre[k], req_wdata, req_strb);
               end
            end
         end else if (!m_idle && resp_ready) begin
            m_idle = 1'b1;
         end
         m_cyc++;
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("req_ready%0d", k),  req_ready[k],  m_idle);
         chk($sformatf("resp_valid%0d", k), resp_valid[k], !m_idle);
         chk($sformatf("irq_sw%0d", k),     irq_sw[k],     m_msip);
         chk($sformatf("irq_timer%0d", k),  irq_t[k],      m_irq[k]);
         chk($sformatf("mtime%0d", k),      mtime[k],      m_time[k]);
         if (!m_idle) begin
            chk($sformatf("rdata%0d", k), resp_rdata[k], m_rd[k]);
            chk($sformatf("err%0d", k),   resp_err[k],   m_err);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic xact(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] strb, input int hold,
                       output logic [63:0] rd0, output logic [63:0] rd1, output logic er);
      int n;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_strb = strb;
      resp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'b0; req_wdata = '0; req_strb = '0;
      chk("accept_at_first_edge", resp_valid[0], 1'b1);
      n = 0;
      while (resp_valid[0] !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (n == 20) chk("resp_timeout", resp_valid[0], 1'b1);
      rd0 = resp_rdata[0]; rd1 = resp_rdata[1]; er = resp_err[0];
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", resp_valid[0], 1'b1);
         chk("hold_rdata", resp_rdata[0], rd0);
         chk("hold_err", resp_err[0], er);
         chk("hold_req_ready", req_ready[0], 1'b0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] r0, r1, v;
      logic        e;
      int          n;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset values
      xact(1'b0, BASE + 64'h0000, '0, 8'h00, 0, r0, r1, e);
      chk("rst_msip", r0, 64'd0);
      xact(1'b0, BASE + 64'h4000, '0, 8'h00, 0, r0, r1, e);
      chk("rst_mtimecmp", r0, 64'hFFFF_FFFF_FFFF_FFFF);
      xact(1'b0, BASE + 64'hBFF8, '0, 8'h00, 0, r0, r1, e);
      chk("rst_mtime_div1", r0, 64'd4);
      chk("rst_mtime_div4", r1, 64'd1);
      repeat (100) @(posedge clk);
      #1;
      chk("rst_irq_timer", irq_t, 2'b00);
      chk("rst_irq_sw", irq_sw, 2'b00);

      // software interrupt and strobes
      xact(1'b1, BASE, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01, 0, r0, r1, e);
      chk("msip_set_irq", irq_sw, 2'b11);
      xact(1'b0, BASE, '0, 8'h00, 0, r0, r1, e);
      chk("msip_read", r0, 64'd1);
      xact(1'b1, BASE, 64'd0, 8'h00, 0, r0, r1, e);
      chk("msip_strb0_keep", irq_sw, 2'b11);
      xact(1'b1, BASE, 64'd0, 8'hFE, 0, r0, r1, e);
      chk("msip_strb_hi_keep", irq_sw, 2'b11);
      xact(1'b1, BASE, 64'd0, 8'h01, 0, r0, r1, e);
      chk("msip_clear", irq_sw, 2'b00);

      xact(1'b1, BASE + 64'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, r0, r1, e);
      xact(1'b1, BASE + 64'h4000, 64'h1122_3344_5566_7788, 8'hF0, 0, r0, r1, e);
      xact(1'b0, BASE + 64'h4000, '0, 8'h00, 0, r0, r1, e);
      chk("cmp_strb_f0", r0, 64'h1122_3344_FFFF_FFFF);
      xact(1'b0, BASE + 64'h4004, '0, 8'h00, 0, r0, r1, e);
      chk("cmp_addr_lsb_ignored", r0, 64'h1122_3344_FFFF_FFFF);
      xact(1'b1, BASE + 64'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, r0, r1, e);

      // prescaler
      xact(1'b1, BASE + 64'hBFF8, 64'd0, 8'hFF, 0, r0, r1, e);
      repeat (40) @(posedge clk);
      #1;
      xact(1'b0, BASE + 64'hBFF8, '0, 8'h00, 0, r0, r1, e);
      chk("presc_div4_about_10", (r1 >= 64'd9 && r1 <= 64'd11), 1'b1);
      v = mtime[1];
      repeat (8) @(posedge clk);
      #1;
      chk("presc_8cyc_2ticks", mtime[1] - v, 64'd2);

      // timer interrupt
      xact(1'b1, BASE + 64'hBFF8, 64'h100, 8'hFF, 0, r0, r1, e);
      xact(1'b1, BASE + 64'h4000, 64'h108, 8'hFF, 0, r0, r1, e);
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (mtime[0] != 64'h108 && n < 30);
      chk("tmr_reach_108", mtime[0], 64'h108);
      chk("tmr_not_yet", irq_t[0], 1'b0);
      @(negedge clk);
      chk("tmr_rise", irq_t[0], 1'b1);
      xact(1'b1, BASE + 64'h4000, 64'hFFFF_0000, 8'hFF, 0, r0, r1, e);
      chk("tmr_deassert", irq_t[0], 1'b0);
      xact(1'b1, BASE + 64'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, r0, r1, e);
      xact(1'b1, BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, r0, r1, e);
      chk("wrap_irq_high", irq_t[0], 1'b1);
      chk("wrap_mtime_zero", mtime[0], 64'd0);
      @(posedge clk); #1;
      chk("wrap_irq_low", irq_t[0], 1'b0);

      // unmapped and backpressure
      xact(1'b0, BASE + 64'h1000, '0, 8'h00, 5, r0, r1, e);
      chk("unmapped_rdata", r0, 64'd0);
      chk("unmapped_err", e, 1'b1);
      chk("ready_after_resp", req_ready, 2'b11);
      xact(1'b0, BASE + 64'h1_4000, '0, 8'h00, 0, r0, r1, e);
      chk("outside_err", e, 1'b1);
      xact(1'b1, BASE + 64'h4008, 64'h0, 8'hFF, 0, r0, r1, e);
      chk("unmapped_wr_err", e, 1'b1);
      xact(1'b0, BASE + 64'h4000, '0, 8'h00, 0, r0, r1, e);
      chk("unmapped_wr_dropped", r0, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("mapped_no_err", e, 1'b0);

      // mid-operation reset
      xact(1'b1, BASE, 64'd1, 8'h01, 0, r0, r1, e);
      req_valid = 1'b1; req_we = 1'b0; req_addr = BASE + 64'hBFF8; resp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("midrst_in_resp", resp_valid, 2'b11);
      rst = 1'b1;
      #1;
      chk("midrst_valid_drop", resp_valid, 2'b00);
      chk("midrst_ready", req_ready, 2'b11);
      chk("midrst_mtime", mtime[0], 64'd0);
      chk("midrst_irq_sw", irq_sw, 2'b00);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      xact(1'b0, BASE + 64'hBFF8, '0, 8'h00, 0, r0, r1, e);
      chk("postrst_mtime_div1", r0, 64'd0);
      chk("postrst_mtime_div4", r1, 64'd0);
      repeat (3) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
